// File: rtl/sb_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sb_param_pkg : shared constants and source-side decode for sb_param       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package sb_param_pkg;

    localparam int          SEL_W           = 2;
    localparam logic [1:0]  SEL_PE          = 2'd3;
    localparam logic [7:0]  REG_WORD_BASE   = 8'h80;
    localparam int          FIELDS_PER_WORD = 16;

    typedef logic [SEL_W-1:0] sel_t;

    // Selects 0..2 walk the other three sides in ascending order, skipping our own.
    function automatic logic [1:0] src_side(input logic [1:0] out_side, input sel_t sel);
        return (sel < out_side) ? sel : sel + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_param_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sb_param_out : one switch-box output, 4:1 mux with optional stallable reg |
// | Optional register build: SB_PARAM_PIPE_REG_EN          Rev 1.0            |
// +--------------------------------------------------------------------------+
module sb_param_out
    import sb_param_pkg::*;
#(
    parameter int WIDTH = 16
) (
`ifdef SB_PARAM_PIPE_REG_EN
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             i_reg_en,
`endif
    input  logic [WIDTH-1:0] i_src0,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [WIDTH-1:0] i_pe,
    input  sel_t             i_sel,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_mux;

    always_comb begin
        w_mux = i_pe;
        case (i_sel)
            2'd0:    w_mux = i_src0;
            2'd1:    w_mux = i_src1;
            2'd2:    w_mux = i_src2;
            SEL_PE:  w_mux = i_pe;
            default: w_mux = i_pe;
        endcase
    end

`ifdef SB_PARAM_PIPE_REG_EN
    logic [WIDTH-1:0] r_pipe;

    // The register keeps tracking the mux even while bypassed, so re-enabling it never exposes stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= '0;
        end else if (!i_stall) begin
            r_pipe <= w_mux;
        end
    end

    assign o_data = i_reg_en ? r_pipe : w_mux;
`else
    assign o_data = w_mux;
`endif

endmodule
`default_nettype wire

// File: rtl/sb_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sb_param : parameterised 4-sided switch box with memory-mapped config     |
// | Optional pipeline registers: SB_PARAM_PIPE_REG_EN      Rev 1.0            |
// +--------------------------------------------------------------------------+
module sb_param
    import sb_param_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          NUM_TRACKS = 2,
    parameter logic [23:0] CFG_BASE   = 24'h000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              pe_output,
    input  logic [4*NUM_TRACKS*WIDTH-1:0] in_data,
    output logic [4*NUM_TRACKS*WIDTH-1:0] out_data,
    input  logic                          stall,
    input  logic                          config_en,
    input  logic                          config_rd,
    input  logic [31:0]                   config_addr,
    input  logic [31:0]                   config_data,
    output logic [31:0]                   config_rdata
);

    localparam int NOUT = 4 * NUM_TRACKS;

    logic [SEL_W*NOUT-1:0] r_sel;
    logic [31:0]           r_rdata;
    logic [31:0]           w_rword;
    logic                  w_hit;
    logic [7:0]            w_word;
    logic                  w_unused_ok;

    assign w_hit  = (config_addr[31:8] == CFG_BASE);
    assign w_word = config_addr[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
        end else if (config_en && w_hit) begin
            for (int o = 0; o < NOUT; o++) begin
                if (w_word == 8'(o / FIELDS_PER_WORD)) begin
                    r_sel[SEL_W*o +: SEL_W] <= config_data[SEL_W*(o % FIELDS_PER_WORD) +: SEL_W];
                end
            end
        end
    end

`ifdef SB_PARAM_PIPE_REG_EN
    logic [NOUT-1:0] r_ren;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ren <= '0;
        end else if (config_en && w_hit) begin
            for (int o = 0; o < NOUT; o++) begin
                if (w_word == REG_WORD_BASE + 8'(o / 32)) begin
                    r_ren[o] <= config_data[o % 32];
                end
            end
        end
    end
`endif

    // Readback is built from the current registers, so a same-cycle write is not visible yet.
    always_comb begin
        w_rword = '0;
        if (w_hit) begin
            for (int o = 0; o < NOUT; o++) begin
                if (w_word == 8'(o / FIELDS_PER_WORD)) begin
                    w_rword[SEL_W*(o % FIELDS_PER_WORD) +: SEL_W] = r_sel[SEL_W*o +: SEL_W];
                end
            end
`ifdef SB_PARAM_PIPE_REG_EN
            for (int o = 0; o < NOUT; o++) begin
                if (w_word == REG_WORD_BASE + 8'(o / 32)) begin
                    w_rword[o % 32] = r_ren[o];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (config_rd) begin
            r_rdata <= w_rword;
        end
    end

    assign config_rdata = r_rdata;

    // Data bits above the populated fields (and stall in the combinational build) are don't-care.
    assign w_unused_ok = ^{config_data, stall};

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
            localparam int O    = s * NUM_TRACKS + t;
            localparam int SRC0 = int'(src_side(2'(s), 2'd0));
            localparam int SRC1 = int'(src_side(2'(s), 2'd1));
            localparam int SRC2 = int'(src_side(2'(s), 2'd2));

            sb_param_out #(
                .WIDTH (WIDTH)
            ) u_out (
`ifdef SB_PARAM_PIPE_REG_EN
                .clk      (clk),
                .reset    (reset),
                .i_stall  (stall),
                .i_reg_en (r_ren[O]),
`endif
                .i_src0   (in_data[(SRC0*NUM_TRACKS+t)*WIDTH +: WIDTH]),
                .i_src1   (in_data[(SRC1*NUM_TRACKS+t)*WIDTH +: WIDTH]),
                .i_src2   (in_data[(SRC2*NUM_TRACKS+t)*WIDTH +: WIDTH]),
                .i_pe     (pe_output),
                .i_sel    (r_sel[SEL_W*O +: SEL_W]),
                .o_data   (out_data[O*WIDTH +: WIDTH])
            );
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sb_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sb_param : self-checking bench for sb_param with a scoreboard queue    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_sb_param;

    localparam int          WIDTH = 16;
    localparam int          NT    = 2;
    localparam int          NOUT  = 4 * NT;
    localparam logic [23:0] BASE  = 24'h00A5C3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         pe_output;
    logic [4*NT*WIDTH-1:0]    in_data;
    logic [4*NT*WIDTH-1:0]    out_data;
    logic                     stall;
    logic                     config_en;
    logic                     config_rd;
    logic [31:0]              config_addr;
    logic [31:0]              config_data;
    logic [31:0]              config_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0]     sb_q[$];
    logic [1:0]      m_sel[NOUT];
    logic [NOUT-1:0] m_ren;

    sb_param #(
        .WIDTH      (WIDTH),
        .NUM_TRACKS (NT),
        .CFG_BASE   (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pe_output    (pe_output),
        .in_data      (in_data),
        .out_data     (out_data),
        .stall        (stall),
        .config_en    (config_en),
        .config_rd    (config_rd),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_rdata (config_rdata)
    );

    always #5 clk = ~clk;

    function automatic int side_of(int s, int sel);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            if (k != s) begin
                if (n == sel) return k;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] in_of(int s, int t);
        return in_data[(s*NT+t)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] out_of(int o);
        return out_data[o*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] model_comb(int o);
        if (m_sel[o] == 2'd3) return pe_output;
        return in_of(side_of(o / NT, int'(m_sel[o])), o % NT);
    endfunction

    function automatic logic [31:0] model_word(logic [7:0] w);
        logic [31:0] r = '0;
        for (int o = 0; o < NOUT; o++)
            if (int'(w) == o / 16) r[2*(o%16) +: 2] = m_sel[o];
`ifdef SB_PARAM_PIPE_REG_EN
        for (int o = 0; o < NOUT; o++)
            if (int'(w) == 128 + o / 32) r[o%32] = m_ren[o];
`endif
        return r;
    endfunction

    task automatic model_write(input logic [7:0] w, input logic [31:0] d);
        for (int o = 0; o < NOUT; o++)
            if (int'(w) == o / 16) m_sel[o] = d[2*(o%16) +: 2];
`ifdef SB_PARAM_PIPE_REG_EN
        for (int o = 0; o < NOUT; o++)
            if (int'(w) == 128 + o / 32) m_ren[o] = d[o%32];
`endif
    endtask

    task automatic model_reset();
        for (int o = 0; o < NOUT; o++) m_sel[o] = 2'd0;
        m_ren = '0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cfg_write(input logic [23:0] tile, input logic [7:0] w, input logic [31:0] d);
        config_en   = 1'b1;
        config_addr = {tile, w};
        config_data = d;
        @(posedge clk);
        #1;
        config_en = 1'b0;
        if (tile == BASE) model_write(w, d);
    endtask

    task automatic cfg_read(input logic [23:0] tile, input logic [7:0] w);
        sb_q.push_back((tile == BASE) ? model_word(w) : 32'h0);
        config_rd   = 1'b1;
        config_addr = {tile, w};
        @(posedge clk);
        #1;
        config_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset       = 1'b1;
        config_en   = 1'b1;
        config_rd   = 1'b1;
        stall       = 1'b1;
        config_addr = {BASE, 8'h00};
        config_data = 32'hFFFF_FFFF;
        pe_output   = 16'h0;
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        config_en = 1'b0;
        config_rd = 1'b0;
        stall     = 1'b0;
        model_reset();
        checks++;
        if (config_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected %h", config_rdata, 32'h0);
        end
        #1;
        for (int o = 0; o < NOUT; o++) begin
            checks++;
            if (out_of(o) !== model_comb(o)) begin
                failures++;
                $display("FAIL reset_out%0d: got %h expected %h", o, out_of(o), model_comb(o));
            end
        end
        in_data[0 +: WIDTH] = 16'h1111;
        #1;
        checks++;
        if (out_of(1*NT+0) !== 16'h1111) begin
            failures++;
            $display("FAIL reset_side1_track0: got %h expected %h", out_of(NT), 16'h1111);
        end
        @(posedge clk);
        #1;
        cfg_read(BASE, 8'h00);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL reset_read_word0: got %h expected %h", config_rdata, exp);
        end
    endtask

    task automatic test_select();
        logic [31:0] exp;
        logic [31:0] pats[5] = '{32'h0000_5555, 32'h0000_AAAA, 32'hFFFF_FFFF, 32'h0000_1B6C, 32'h0};
        pe_output = 16'hBEEF;
        cfg_write(BASE, 8'h00, 32'h0000_00C0);
        checks++;
        if (out_of(3) !== 16'hBEEF) begin
            failures++;
            $display("FAIL sel_pe_out3: got %h expected %h", out_of(3), 16'hBEEF);
        end
        cfg_read(BASE, 8'h00);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp || exp !== 32'h0000_00C0) begin
            failures++;
            $display("FAIL sel_read_c0: got %h expected %h", config_rdata, 32'h0000_00C0);
        end
        for (int i = 0; i < 9; i++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            pe_output = 16'($urandom);
            cfg_write(BASE, 8'h00, (i < 5) ? pats[i] : $urandom);
            for (int o = 0; o < NOUT; o++) begin
                checks++;
                if (out_of(o) !== model_comb(o)) begin
                    failures++;
                    $display("FAIL sel_pat%0d_out%0d: got %h expected %h", i, o, out_of(o), model_comb(o));
                end
            end
            cfg_read(BASE, 8'h00);
            exp = sb_q.pop_front();
            checks++;
            if (config_rdata !== exp) begin
                failures++;
                $display("FAIL sel_pat%0d_read: got %h expected %h", i, config_rdata, exp);
            end
        end
    endtask

    task automatic test_unmatched();
        logic [31:0] exp;
        cfg_write(BASE + 24'd1, 8'h00, 32'hFFFF_FFFF);
        for (int o = 0; o < NOUT; o++) begin
            checks++;
            if (out_of(o) !== model_comb(o)) begin
                failures++;
                $display("FAIL unmatched_out%0d: got %h expected %h", o, out_of(o), model_comb(o));
            end
        end
        cfg_read(BASE + 24'd1, 8'h00);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL unmatched_read: got %h expected %h", config_rdata, exp);
        end
        cfg_read(BASE, 8'h00);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL unmatched_word0_kept: got %h expected %h", config_rdata, exp);
        end
        cfg_write(BASE, 8'h01, 32'hFFFF_FFFF);
        cfg_read(BASE, 8'h01);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL unused_word1: got %h expected %h", config_rdata, exp);
        end
`ifndef SB_PARAM_PIPE_REG_EN
        cfg_write(BASE, 8'h80, 32'hFFFF_FFFF);
        for (int o = 0; o < NOUT; o++) begin
            checks++;
            if (out_of(o) !== model_comb(o)) begin
                failures++;
                $display("FAIL noreg_out%0d: got %h expected %h", o, out_of(o), model_comb(o));
            end
        end
`endif
        cfg_read(BASE, 8'h80);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL reg_word_read: got %h expected %h", config_rdata, exp);
        end
    endtask

    task automatic test_rw_same();
        logic [31:0] exp;
        cfg_write(BASE, 8'h00, 32'h0000_3C3C);
        sb_q.push_back(model_word(8'h00));
        config_en   = 1'b1;
        config_rd   = 1'b1;
        config_addr = {BASE, 8'h00};
        config_data = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        config_en = 1'b0;
        config_rd = 1'b0;
        model_write(8'h00, 32'hAAAA_AAAA);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL rw_same_old: got %h expected %h", config_rdata, exp);
        end
        config_addr = {BASE + 24'd1, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL rdata_hold: got %h expected %h", config_rdata, exp);
        end
        cfg_read(BASE, 8'h00);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp || exp !== 32'h0000_AAAA) begin
            failures++;
            $display("FAIL rw_same_new: got %h expected %h", config_rdata, 32'h0000_AAAA);
        end
    endtask

`ifdef SB_PARAM_PIPE_REG_EN
    task automatic test_pipe();
        logic [31:0] exp;
        logic [31:0] v;
        cfg_write(BASE, 8'h00, 32'h0);
        cfg_write(BASE, 8'h80, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            in_data[(1*NT+0)*WIDTH +: WIDTH] = 16'(i);
            sb_q.push_back(32'(i));
            @(posedge clk);
            #1;
            v = sb_q.pop_front();
            checks++;
            if (out_of(0) !== v[WIDTH-1:0]) begin
                failures++;
                $display("FAIL pipe_ramp%0d: got %h expected %h", i, out_of(0), v[WIDTH-1:0]);
            end
        end
        stall = 1'b1;
        in_data[(1*NT+0)*WIDTH +: WIDTH] = 16'h0009;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_of(0) !== 16'h0003) begin
                failures++;
                $display("FAIL pipe_stall%0d: got %h expected %h", i, out_of(0), 16'h0003);
            end
            checks++;
            if (out_of(1) !== model_comb(1)) begin
                failures++;
                $display("FAIL stall_comb%0d: got %h expected %h", i, out_of(1), model_comb(1));
            end
        end
        stall = 1'b0;
        in_data[(1*NT+0)*WIDTH +: WIDTH] = 16'h5A5A;
        @(posedge clk);
        #1;
        checks++;
        if (out_of(0) !== 16'h5A5A) begin
            failures++;
            $display("FAIL pipe_5a5a: got %h expected %h", out_of(0), 16'h5A5A);
        end
        reset = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        in_data[(1*NT+0)*WIDTH +: WIDTH] = 16'h1234;
        #1;
        checks++;
        if (out_of(0) !== 16'h1234) begin
            failures++;
            $display("FAIL reset_path_comb: got %h expected %h", out_of(0), 16'h1234);
        end
        cfg_read(BASE, 8'h80);
        exp = sb_q.pop_front();
        checks++;
        if (config_rdata !== exp) begin
            failures++;
            $display("FAIL reset_ren_cleared: got %h expected %h", config_rdata, exp);
        end
        cfg_write(BASE, 8'h80, 32'h1);
        checks++;
        if (out_of(0) !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pipe_cleared: got %h expected %h", out_of(0), 16'h0000);
        end
        stall = 1'b0;
        cfg_write(BASE, 8'h80, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_unmatched();
        test_rw_same();
`ifdef SB_PARAM_PIPE_REG_EN
        test_pipe();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_param.md
SB_PARAM -- requirements
Module: sb_param

Interface
- Parameters (name, default, meaning):
  - REQ-001 The block SHALL have parameter WIDTH, default 16: data bits per track.
  - REQ-002 The block SHALL have parameter NUM_TRACKS, default 2: tracks per side, legal range 1..16.
  - REQ-003 The block SHALL have parameter CFG_BASE, default 24'h000000: tile address matched against config_addr[31:8].
- Ports (name, direction, width, meaning):
  - REQ-004 The block SHALL have port clk, input, 1: clock; all state updates on its rising edge.
  - REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high.
  - REQ-006 The block SHALL have port pe_output, input, WIDTH: PE result, shared by all outputs.
  - REQ-007 The block SHALL have port in_data, input, 4*NUM_TRACKS*WIDTH: side s, track t at bits [(s*NUM_TRACKS+t)*WIDTH +: WIDTH].
  - REQ-008 The block SHALL have port out_data, output, 4*NUM_TRACKS*WIDTH: same packing as in_data.
  - REQ-009 The block SHALL have port stall, input, 1: holds all pipeline registers.
  - REQ-010 The block SHALL have ports config_en, input, 1 (write strobe), and config_rd, input, 1 (read strobe).
  - REQ-011 The block SHALL have ports config_addr, input, 32 and config_data, input, 32.
  - REQ-012 The block SHALL have port config_rdata, output, 32: readback data.

Function
- REQ-013 Output o = s*NUM_TRACKS+t SHALL select by a 2-bit field: 0,1,2 = in_data of the other three sides, same track, in ascending side order; 3 = pe_output.
- REQ-014 A config access SHALL be addressed only when config_addr[31:8]==CFG_BASE; let w = config_addr[7:0].
- REQ-015 Select words SHALL be w = 0..ceil(4*NUM_TRACKS/16)-1; output o's field is word o/16, bits [2*(o%16)+:2].
- REQ-016 Register-enable words SHALL be w = 8'h80 + j; bit b enables the pipeline register of output 32*j+b.
- REQ-017 An addressed write with config_en=1 SHALL update the full word on the clock edge; the new select SHALL steer out_data from the following cycle.
- REQ-018 Writes to unmatched tiles, unused words or bits beyond the output count SHALL be ignored.
- REQ-019 Unused bits SHALL read as 0.
- REQ-020 config_rd=1 SHALL return the addressed word on config_rdata one cycle later; unmatched or unused addresses SHALL return 0; config_rdata SHALL hold its value until the next read.
- REQ-021 On a simultaneous write and read of the same word, the read SHALL return the pre-write value.
- REQ-022 An output with its register-enable bit clear SHALL be combinational from the selected source (0-cycle latency).
- REQ-023 An output with its register-enable bit set SHALL present the mux result registered (1-cycle latency).
- REQ-024 With stall=1, all pipeline registers SHALL hold; combinational outputs and config accesses SHALL be unaffected by stall.
- REQ-025 Toggling an output's register-enable bit SHALL switch its output path on the next cycle without clearing its pipeline register.

Reset
- REQ-026 Reset SHALL clear all select words to 0, all register-enable words to 0, all pipeline registers to 0, and config_rdata to 0.
- REQ-027 Reset SHALL override config_en, config_rd and stall in the same cycle.
- REQ-028 After reset every output SHALL equal the side-relative source 0 input, combinationally.
- REQ-029 A reset asserted mid-stream SHALL discard all held pipeline data.

Configuration
- REQ-030 With macro SB_PARAM_PIPE_REG_EN defined, the register-enable words, pipeline registers and stall behaviour SHALL be compiled in.
- REQ-031 Without SB_PARAM_PIPE_REG_EN, no pipeline registers SHALL exist, all outputs SHALL be combinational, writes to 8'h80+ words SHALL be ignored and their reads SHALL return 0, and stall SHALL be unused.

Structure
- REQ-032 Package sb_param_pkg SHALL hold SEL_W=2, SEL_PE=2'd3, REG_WORD_BASE=8'h80, FIELDS_PER_WORD=16, and the function returning the side index for a given output side and select.
- REQ-033 Sub-module sb_param_out SHALL implement one output: a 4:1 mux plus an optional stallable register, instantiated 4*NUM_TRACKS times by generate.

Verification
- REQ-034 After reset with NUM_TRACKS=2, drive in side0/track0=16'h1111 -> out side1/track0=16'h1111, and config_rdata=0 after any read.
- REQ-035 Write word0=32'h0000_00C0 (output 3, side1/track1, sel=3), pe_output=16'hBEEF -> out side1/track1=16'hBEEF the cycle after the write; read word0 -> 32'h0000_00C0 one cycle later.
- REQ-036 Write with config_addr[31:8]=CFG_BASE+1, data 32'hFFFF_FFFF -> all outputs unchanged; read word0 -> 0.
- REQ-037 (SB_PARAM_PIPE_REG_EN) Write word 8'h80=32'h1, ramp side1/track0 input 1,2,3 -> out side0/track0 shows 1,2,3 delayed by one cycle; stall=1 for 2 cycles -> output held at the stalled value.
- REQ-038 Simultaneous write and read of word0 with new data 32'hAAAA_AAAA -> rdata returns the old value; the next read returns 32'hAAAA_AAAA masked to the valid field bits.
- REQ-039 Assert reset while a registered output holds 16'h5A5A -> output 0 next cycle, with the register-enable bit cleared.
